// File: rtl/i2c_bit_driver_pkg.sv
// Command encodings, phase indices and per-command SCL/SDA phase patterns
// shared by the I2C bit driver and its quarter-phase divider.
package i2c_bit_driver_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE  = 3'd0,
        CMD_START = 3'd1,
        CMD_STOP  = 3'd2,
        CMD_BIT0  = 3'd3,
        CMD_BIT1  = 3'd4,
        CMD_RBIT  = 3'd5,
        CMD_WAIT  = 3'd6,
        CMD_RSVD  = 3'd7
    } cmd_e;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_FIRST  = 2'd0;
    localparam phase_t PH_SAMPLE = 2'd2;
    localparam phase_t PH_LAST   = 2'd3;

    // Line levels, 1 = released.
    typedef struct packed {
        logic scl;
        logic sda;
    } lines_t;

    // Bit p of each mask is the released level during phase p.
    localparam logic [3:0] START_SCL = 4'b0111;
    localparam logic [3:0] START_SDA = 4'b0011;
    localparam logic [3:0] BIT_SCL   = 4'b0110;
    localparam logic [3:0] STOP_SCL  = 4'b1110;
    localparam logic [3:0] STOP_SDA  = 4'b1100;

    function automatic logic is_exec_cmd(input cmd_e c);
        logic r;
        case (c)
            CMD_START, CMD_STOP, CMD_BIT0, CMD_BIT1, CMD_RBIT: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic lines_t phase_lines(input cmd_e c, input phase_t p);
        lines_t l;
        l.scl = 1'b1;
        l.sda = 1'b1;
        case (c)
            CMD_START: begin
                l.scl = START_SCL[p];
                l.sda = START_SDA[p];
            end
            CMD_BIT0: begin
                l.scl = BIT_SCL[p];
                l.sda = 1'b0;
            end
            CMD_BIT1, CMD_RBIT: begin
                l.scl = BIT_SCL[p];
                l.sda = 1'b1;
            end
            CMD_STOP: begin
                l.scl = STOP_SCL[p];
                l.sda = STOP_SDA[p];
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/i2c_bit_driver_quarter_tick.sv
// Quarter-bit divider: counts 0..CLK_DIV-1 while running, freezes on hold,
// and restarts from zero when a new command is accepted.
module i2c_quarter_tick #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    input  logic hold,
    output logic tick,
    output logic tick_next
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The terminal count always completes, so a stretch seen in the last
    // cycle of a phase cannot retract an already-announced phase end.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || !run) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick      = run && (cnt_q == TERM);
    assign tick_next = run && (cnt_d == TERM);

endmodule

// File: rtl/i2c_bit_driver.sv
// Converts one transaction-generator command into four timed quarter-phases
// on open-drain SCL/SDA enables, sampling SDA for read/ACK bits.
module i2c_bit_driver
    import i2c_bit_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 125,
    parameter bit          STRETCH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] command,
    output logic       bitready,
    output logic       busy,
    output logic       rdata,
    output logic       nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    state_e state_q, state_d;
    phase_t phase_q, phase_d;
    cmd_e   cmd_q,   cmd_d;
    logic   scl_oe_q, scl_oe_d;
    logic   sda_oe_q, sda_oe_d;
    logic   bitready_q, bitready_d;
    logic   busy_q, busy_d;
    logic   rdata_q, rdata_d;
    logic   nack_q, nack_d;

    cmd_e   cmd_in;
    logic   accept;
    logic   running;
    logic   hold;
    logic   tick;
    logic   tick_next;
    lines_t cur_lines;
    lines_t first_lines;
    lines_t next_lines;

    assign cmd_in      = cmd_e'(command);
    assign running     = (state_q == ST_RUN);
    assign accept      = (state_q == ST_READY) && is_exec_cmd(cmd_in);
    assign cur_lines   = phase_lines(cmd_q, phase_q);
    assign first_lines = phase_lines(cmd_in, PH_FIRST);
    assign next_lines  = phase_lines(cmd_q, phase_t'(phase_q + phase_t'(1)));

    // A slave may only stretch while we have SCL released.
    assign hold = STRETCH_EN && running && cur_lines.scl && !scl_in;

    i2c_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .run       (running),
        .restart   (accept),
        .hold      (hold),
        .tick      (tick),
        .tick_next (tick_next)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cmd_d      = cmd_q;
        scl_oe_d   = scl_oe_q;
        sda_oe_d   = sda_oe_q;
        bitready_d = 1'b0;
        busy_d     = busy_q;
        rdata_d    = rdata_q;
        nack_d     = nack_q;

        case (state_q)
            ST_READY: begin
                if (accept) begin
                    state_d  = ST_RUN;
                    phase_d  = PH_FIRST;
                    cmd_d    = cmd_in;
                    busy_d   = 1'b1;
                    scl_oe_d = ~first_lines.scl;
                    sda_oe_d = ~first_lines.sda;
                    if (cmd_in == CMD_START) begin
                        nack_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (tick) begin
                    if (phase_q == PH_LAST) begin
                        state_d = ST_READY;
                        busy_d  = 1'b0;
                    end else begin
                        phase_d  = phase_t'(phase_q + phase_t'(1));
                        scl_oe_d = ~next_lines.scl;
                        sda_oe_d = ~next_lines.sda;
                    end
                end
                // Registered pulse lands on the final cycle of phase 3.
                if ((phase_q == PH_LAST) && tick_next) begin
                    bitready_d = 1'b1;
                end
                if ((cmd_q == CMD_RBIT) && (phase_q == PH_SAMPLE) && tick) begin
                    rdata_d = sda_in;
                    if (sda_in) begin
                        nack_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_READY;
            phase_q    <= '0;
            cmd_q      <= CMD_IDLE;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            bitready_q <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cmd_q      <= cmd_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            bitready_q <= bitready_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
            nack_q     <= nack_d;
        end
    end

    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;
    assign bitready = bitready_q;
    assign busy     = busy_q;
    assign rdata    = rdata_q;
    assign nack     = nack_q;

endmodule

// File: tb/tb_i2c_bit_driver.sv
// Scoreboard bench for i2c_bit_driver: stimulus tasks push one expected
// output record per clock cycle, a negedge monitor pops and compares.
module tb_i2c_bit_driver;

    localparam int unsigned CLK_DIV = 4;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_START = 3'd1;
    localparam logic [2:0] C_STOP  = 3'd2;
    localparam logic [2:0] C_BIT0  = 3'd3;
    localparam logic [2:0] C_BIT1  = 3'd4;
    localparam logic [2:0] C_RBIT  = 3'd5;
    localparam logic [2:0] C_WAIT  = 3'd6;
    localparam logic [2:0] C_RSVD  = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] command;
    logic       bitready, busy, rdata, nack, scl_oe, sda_oe;
    logic       scl_in, sda_in;
    logic       stretch_force;

    // Bus model: SCL reads low when we pull it or a slave stretches.
    assign scl_in = ~scl_oe & ~stretch_force;

    i2c_bit_driver #(
        .CLK_DIV    (CLK_DIV),
        .STRETCH_EN (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .command  (command),
        .bitready (bitready),
        .busy     (busy),
        .rdata    (rdata),
        .nack     (nack),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .scl_in   (scl_in),
        .sda_in   (sda_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic scl_oe;
        logic sda_oe;
        logic busy;
        logic bitready;
        logic rdata;
        logic nack;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic m_scl_oe, m_sda_oe, m_rdata, m_nack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void ref_lines(input logic [2:0] c, input int p,
                                      output logic scl, output logic sda);
        case (c)
            C_START: begin scl = (p != 3);            sda = (p < 2);      end
            C_BIT0:  begin scl = (p == 1 || p == 2);  sda = 1'b0;         end
            C_BIT1:  begin scl = (p == 1 || p == 2);  sda = 1'b1;         end
            C_RBIT:  begin scl = (p == 1 || p == 2);  sda = 1'b1;         end
            C_STOP:  begin scl = (p != 0);            sda = (p >= 2);     end
            default: begin scl = 1'b1;                sda = 1'b1;         end
        endcase
    endfunction

    task automatic push_rec(input logic b, input logic br);
        exp_t e;
        e.scl_oe   = m_scl_oe;
        e.sda_oe   = m_sda_oe;
        e.busy     = b;
        e.bitready = br;
        e.rdata    = m_rdata;
        e.nack     = m_nack;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("scl_oe",   scl_oe,   e.scl_oe);
            chk("sda_oe",   sda_oe,   e.sda_oe);
            chk("busy",     busy,     e.busy);
            chk("bitready", bitready, e.bitready);
            chk("rdata",    rdata,    e.rdata);
            chk("nack",     nack,     e.nack);
        end
    end

    // Presents a command in the current (READY) cycle and walks all phases;
    // phase 1 is lengthened by 'stretch' cycles of slave clock stretching.
    task automatic do_cmd(input logic [2:0] c, input logic sbit, input int unsigned stretch);
        logic scl, sda;
        int unsigned len;
        command = c;
        sda_in  = sbit;
        push_rec(1'b0, 1'b0);
        step();
        for (int p = 0; p < 4; p++) begin
            len = CLK_DIV + ((p == 1) ? stretch : 0);
            for (int unsigned i = 0; i < len; i++) begin
                stretch_force = (p == 1) && (i < stretch);
                ref_lines(c, p, scl, sda);
                m_scl_oe = ~scl;
                m_sda_oe = ~sda;
                if (c == C_START && p == 0 && i == 0) m_nack = 1'b0;
                if (c == C_RBIT && p == 3 && i == 0) begin
                    m_rdata = sbit;
                    if (sbit) m_nack = 1'b1;
                end
                push_rec(1'b1, (p == 3) && (i == len - 1));
                step();
            end
        end
        stretch_force = 1'b0;
        command = C_WAIT;
    endtask

    task automatic idle_hold(input logic [2:0] c, input int unsigned n);
        command = c;
        repeat (n) begin
            push_rec(1'b0, 1'b0);
            step();
        end
    endtask

    task automatic reset_mid_bit0();
        logic scl, sda;
        command = C_BIT0;
        push_rec(1'b0, 1'b0);
        step();
        for (int unsigned k = 0; k < 2 * CLK_DIV + 1; k++) begin
            ref_lines(C_BIT0, int'(k / CLK_DIV), scl, sda);
            m_scl_oe = ~scl;
            m_sda_oe = ~sda;
            push_rec(1'b1, 1'b0);
            step();
        end
        // Second cycle of phase 2: reset strikes mid-cycle.
        #2;
        reset   = 1'b1;
        command = C_IDLE;
        #1;
        chk("rst_scl_oe",   scl_oe,   1'b0);
        chk("rst_sda_oe",   sda_oe,   1'b0);
        chk("rst_busy",     busy,     1'b0);
        chk("rst_bitready", bitready, 1'b0);
        m_scl_oe = 1'b0;
        m_sda_oe = 1'b0;
        m_rdata  = 1'b0;
        m_nack   = 1'b0;
        step();
        idle_hold(C_IDLE, 2);
        reset = 1'b0;
        idle_hold(C_IDLE, 3);
    endtask

    initial begin
        reset         = 1'b1;
        command       = C_IDLE;
        sda_in        = 1'b1;
        stretch_force = 1'b0;
        m_scl_oe      = 1'b0;
        m_sda_oe      = 1'b0;
        m_rdata       = 1'b0;
        m_nack        = 1'b0;
        step();
        idle_hold(C_IDLE, 2);
        reset = 1'b0;
        idle_hold(C_IDLE, 2);

        do_cmd(C_START, 1'b1, 0);
        do_cmd(C_BIT1,  1'b1, 0);
        idle_hold(C_WAIT, 1);
        do_cmd(C_BIT0,  1'b1, 0);
        idle_hold(C_WAIT, 1);

        do_cmd(C_RBIT, 1'b0, 0);
        idle_hold(C_WAIT, 1);
        do_cmd(C_RBIT, 1'b1, 0);
        idle_hold(C_WAIT, 1);
        do_cmd(C_START, 1'b1, 0);
        idle_hold(C_WAIT, 1);

        do_cmd(C_BIT1, 1'b1, 10);
        idle_hold(C_WAIT, 1);

        idle_hold(C_IDLE, 100);
        idle_hold(C_WAIT, 100);
        idle_hold(C_RSVD, 100);

        reset_mid_bit0();
        do_cmd(C_STOP, 1'b1, 0);
        idle_hold(C_WAIT, 3);

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_bit_driver.md
Name: i2c_bit_driver

Overview:
Bit-level I2C line driver that directly consumes the 3-bit command stream of the I2C transaction generator (CMDSTART/CMDBIT0/CMDBIT1/CMDRBIT/CMDSTOP) and returns a one-cycle bitready per completed bus operation. It converts each command into four timed quarter-phases on open-drain SCL/SDA enables and samples SDA for read/ACK bits. It sits between the transaction generator and the codec I2C pins in the sinewave-generator design.

Parameters:
CLK_DIV, 125, clk cycles per quarter-bit phase (50 MHz / (4*125) = 100 kHz SCL); legal range >= 2.
STRETCH_EN, 1, 1 = honour slave clock stretching on SCL; 0 = ignore scl_in.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
command  in  3  bit command from the transaction generator (bit_stream.h encodings).
bitready  out  1  one-cycle pulse: current command finished.
busy  out  1  high while a command is executing.
rdata  out  1  SDA value sampled during the last CMDRBIT; valid from the bitready cycle.
nack  out  1  sticky flag: a CMDRBIT sampled 1; cleared on CMDSTART acceptance.
scl_oe  out  1  1 = pull SCL low, 0 = release.
sda_oe  out  1  1 = pull SDA low, 0 = release.
scl_in  in  1  SCL pin level (pre-synchronised externally).
sda_in  in  1  SDA pin level (pre-synchronised externally).

Behaviour:
- Async reset: scl_oe=0, sda_oe=0, bitready=0, busy=0, rdata=0, nack=0, FSM=READY, phase=0, divider count=0.
- FSM states: READY, RUN. Phase counter 0..3. Divider counter 0..CLK_DIV-1, width $clog2(CLK_DIV).
- READY: command in {START, STOP, BIT0, BIT1, RBIT} is latched at cycle t. FSM goes to RUN with phase 0 and busy=1 from t+1.
- READY ignores CMDIDLE, CMDWAIT and code 7. Lines hold their last levels.
- Commands are accepted only in READY, never in the bitready cycle. The generator's same-cycle switch to CMDWAIT therefore needs no extra guard.
- Each phase lasts CLK_DIV cycles. bitready=1 in the final cycle of phase 3, which is cycle t+4*CLK_DIV with no stretching. The FSM returns to READY the next cycle and can accept a new command that same cycle.
- Line levels per phase, as SCL/SDA (1 = released):
  - START: 1/1, 1/1, 1/0, 0/0.
  - BITx: 0/x, 1/x, 1/x, 0/x.
  - RBIT: 0/1, 1/1, 1/1, 0/1.
  - STOP: 0/0, 1/0, 1/1, 1/1.
- Outputs are registered. scl_oe = ~SCL and sda_oe = ~SDA of the active phase.
- After a command completes, phase-3 levels are held while in READY. After STOP both lines are released.
- RBIT: sda_in is sampled in the last cycle of phase 2 into rdata. If the sampled value is 1, nack is set.
- Clock stretching (STRETCH_EN=1): in any phase where SCL is released, the divider freezes while scl_in=0. The phase resumes counting once scl_in=1, so bitready is delayed by the stretch length.
- A latched command cannot change mid-operation; command input changes during RUN are ignored.
- Reset mid-operation: lines are released immediately (asynchronously), with no bitready and no partial-bit completion. The FSM restarts in READY.

Decomposition:
- bit_stream.h holds the command encodings: CMDIDLE=0, CMDSTART=1, CMDSTOP=2, CMDBIT0=3, CMDBIT1=4, CMDRBIT=5, CMDWAIT=6; code 7 is reserved. It also holds the phase indices and the per-command SCL/SDA phase patterns.
- Sub-module i2c_quarter_tick: the CLK_DIV divider with a hold (stretch) input and a tick output; restarted on command acceptance.

Test Plan:
- CLK_DIV=4, reset, then CMDSTART held until bitready (acceptance at cycle t):
  - sda_oe rises at t+9, scl_oe rises at t+13.
  - bitready pulses only at t+16; busy=0 at t+17.
- BIT1 then BIT0, each followed by a CMDWAIT cycle:
  - BIT1: sda_oe=0 for all 16 cycles.
  - BIT0: sda_oe=1 for all 16 cycles.
  - scl_oe pattern 1,0,0,1 per quarter; exactly one bitready per command.
- RBIT with sda_in=0 → rdata=0, nack=0. RBIT with sda_in=1 → rdata=1, nack=1. A subsequent CMDSTART acceptance → nack=0.
- STRETCH_EN=1, BIT1 with scl_in forced 0 for 10 cycles during phase 1 → bitready at t+26; SCL phase order unchanged.
- Reset asserted in phase 2 of BIT0 → scl_oe=sda_oe=0 in the same cycle, no bitready. After release, CMDSTOP completes in 16 cycles.
- CMDIDLE, CMDWAIT and code 7 each held 100 cycles → busy=0, bitready never asserts, line enables unchanged.
